data_seq: RTL

DATA_SEQ -- requirements
Module: data_seq

---
 rtl/data_seq_pkg.sv | 35 +++
 rtl/data_seq_timer.sv | 26 ++
 rtl/data_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_seq_pkg.sv
// Shared definitions for the SD data-path sequencer: state encoding, error codes
// and default limits.
package data_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_REQ    = 3'd1,
      ST_RD_WAIT   = 3'd2,
      ST_PROC_REQ  = 3'd3,
      ST_PROC_WAIT = 3'd4,
      ST_WR_REQ    = 3'd5,
      ST_WR_WAIT   = 3'd6,
      ST_FINISH    = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_CRC     = 2'b01,
      ERR_TIMEOUT = 2'b10
   } err_e;

   localparam int unsigned DEF_MAX_RETRY = 3;
   localparam logic [15:0] DEF_TIMEOUT   = 16'd50000;

   // Phases in which the timeout counter is armed and running.
   function automatic logic is_wait(input state_e s);
      return (s == ST_RD_WAIT) || (s == ST_PROC_WAIT) || (s == ST_WR_WAIT);
   endfunction

   // Request phases reload the timeout counter for the wait that follows.
   function automatic logic is_req(input state_e s);
      return (s == ST_RD_REQ) || (s == ST_PROC_REQ) || (s == ST_WR_REQ);
   endfunction

endpackage

// File: rtl/data_seq_timer.sv
// Loadable 16-bit down-counter that sticks at zero; ozero flags expiry.
module data_seq_timer (
   input  logic        iclk,
   input  logic        irst,
   input  logic        iload,
   input  logic        ien,
   input  logic [15:0] iload_val,
   output logic        ozero
);

   logic [15:0] cnt_q;

   // NOTE: non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge iclk) begin
      if (irst) begin
         cnt_q <= '0;
      end else if (iload) begin
         cnt_q <= iload_val;
      end else if (ien && (cnt_q != 16'd0)) begin
         cnt_q <= cnt_q - 16'd1;
      end
   end

   assign ozero = (cnt_q == 16'd0);

endmodule

// File: rtl/data_seq.sv
// Block sequencer: read block from D-line driver, hand it to the cipher core,
// write it back, repeat for the requested count with CRC retry and timeouts.
module data_seq
   import data_seq_pkg::*;
#(
   parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
   parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT
) (
   input  logic       iclk,
   input  logic       irst,
   input  logic       istart,
   input  logic [7:0] iblk_cnt,
   output logic       ostart_read,
   output logic       ostart_write,
   input  logic       idrv_done,
   input  logic       idrv_crc_fail,
   output logic       ostart_proc,
   input  logic       iproc_done,
   output logic       obusy,
   output logic       odone,
   output logic [1:0] oerr,
   output logic [7:0] oblk_idx
);

   localparam logic [2:0]  RETRY_LIM = 3'(MAX_RETRY);
   localparam logic [15:0] TO_LOAD   = TIMEOUT - 16'd1;

   state_e     state_q, state_d;
   err_e       err_q, err_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] idx_q, idx_d;
   logic [2:0] retry_q, retry_d;
   logic       seen_low_q, seen_low_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       rd_q, rd_d;
   logic       wr_q, wr_d;
   logic       proc_q, proc_d;

   logic       tmr_zero;
   logic       drv_complete;

   data_seq_timer u_timer (
      .iclk      (iclk),
      .irst      (irst),
      .iload     (is_req(state_q)),
      .ien       (is_wait(state_q)),
      .iload_val (TO_LOAD),
      .ozero     (tmr_zero)
   );

   // The driver idles high, so only a rising return after a seen low counts.
   assign drv_complete = idrv_done & seen_low_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d    = state_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      retry_d    = retry_q;
      seen_low_d = seen_low_q;

      unique case (state_q)
         ST_IDLE: begin
            if (istart) begin
               cnt_d   = (iblk_cnt == 8'd0) ? 8'd1 : iblk_cnt;
               idx_d   = 8'd0;
               retry_d = 3'd0;
               err_d   = ERR_OK;
               state_d = ST_RD_REQ;
            end
         end

         ST_RD_REQ: begin
            seen_low_d = 1'b0;
            state_d    = ST_RD_WAIT;
         end

         ST_RD_WAIT: begin
            seen_low_d = seen_low_q | ~idrv_done;
            if (drv_complete) begin
               if (!idrv_crc_fail) begin
                  retry_d = 3'd0;
                  state_d = ST_PROC_REQ;
               end else if (retry_q < RETRY_LIM) begin
                  retry_d = retry_q + 3'd1;
                  state_d = ST_RD_REQ;
               end else begin
                  err_d   = ERR_CRC;
                  state_d = ST_FINISH;
               end
            end else if (tmr_zero) begin
               err_d   = ERR_TIMEOUT;
               state_d = ST_FINISH;
            end
         end

         ST_PROC_REQ: begin
            state_d = ST_PROC_WAIT;
         end

         ST_PROC_WAIT: begin
            if (iproc_done) begin
               state_d = ST_WR_REQ;
            end else if (tmr_zero) begin
               err_d   = ERR_TIMEOUT;
               state_d = ST_FINISH;
            end
         end

         ST_WR_REQ: begin
            seen_low_d = 1'b0;
            state_d    = ST_WR_WAIT;
         end

         ST_WR_WAIT: begin
            seen_low_d = seen_low_q | ~idrv_done;
            if (drv_complete) begin
               if (idx_q == (cnt_q - 8'd1)) begin
                  state_d = ST_FINISH;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = ST_RD_REQ;
               end
            end else if (tmr_zero) begin
               err_d   = ERR_TIMEOUT;
               state_d = ST_FINISH;
            end
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they leave the flops aligned
      // with the state they belong to.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FINISH);
      rd_d   = (state_d == ST_RD_REQ);
      wr_d   = (state_d == ST_WR_REQ);
      proc_d = (state_d == ST_PROC_REQ);
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q    <= ST_IDLE;
         err_q      <= ERR_OK;
         cnt_q      <= 8'd0;
         idx_q      <= 8'd0;
         retry_q    <= 3'd0;
         seen_low_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         proc_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         retry_q    <= retry_d;
         seen_low_q <= seen_low_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         proc_q     <= proc_d;
      end
   end

   assign ostart_read  = rd_q;
   assign ostart_write = wr_q;
   assign ostart_proc  = proc_q;
   assign obusy        = busy_q;
   assign odone        = done_q;
   assign oerr         = err_q;
   assign oblk_idx     = idx_q;

endmodule
